// File: rtl/stopwatch_ctrl_if.sv
// Button/switch inputs and command outputs exchanged between the stopwatch
// control block (master) and the counter datapath / board I/O side (slave).
interface stopwatch_ctrl_if;
   logic btnP;
   logic btnR;
   logic swADJ;
   logic swSEL;
   logic inc_sec;
   logic inc_min;
   logic clear;
   logic paused;
   logic adj_mode;
   logic blink_sec;
   logic blink_min;

   modport master (
      input  btnP,
      input  btnR,
      input  swADJ,
      input  swSEL,
      output inc_sec,
      output inc_min,
      output clear,
      output paused,
      output adj_mode,
      output blink_sec,
      output blink_min
   );

   modport slave (
      output btnP,
      output btnR,
      output swADJ,
      output swSEL,
      input  inc_sec,
      input  inc_min,
      input  clear,
      input  paused,
      input  adj_mode,
      input  blink_sec,
      input  blink_min
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions buttons and switches, holds pause flag and mode,
// and issues one-cycle increment/clear commands plus display blink enables.
module stopwatch_ctrl #(
   parameter int unsigned CLK_DIV_1HZ   = 100_000_000,
   parameter int unsigned CLK_DIV_ADJ   = 50_000_000,
   parameter int unsigned CLK_DIV_BLINK = 25_000_000,
   parameter int unsigned DB_CYCLES     = 1_000_000
) (
   input logic              clk,
   input logic              rst,
   stopwatch_ctrl_if.master bus
);

   localparam int unsigned WidthNorm  = (CLK_DIV_1HZ > 1) ? $clog2(CLK_DIV_1HZ) : 1;
   localparam int unsigned WidthAdj   = (CLK_DIV_ADJ > 1) ? $clog2(CLK_DIV_ADJ) : 1;
   localparam int unsigned WidthBlink = (CLK_DIV_BLINK > 1) ? $clog2(CLK_DIV_BLINK) : 1;
   localparam int unsigned WidthDb    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   localparam logic [WidthNorm-1:0]  LastNorm  = WidthNorm'(CLK_DIV_1HZ - 1);
   localparam logic [WidthAdj-1:0]   LastAdj   = WidthAdj'(CLK_DIV_ADJ - 1);
   localparam logic [WidthBlink-1:0] LastBlink = WidthBlink'(CLK_DIV_BLINK - 1);
   localparam logic [WidthDb-1:0]    LastDb    = WidthDb'(DB_CYCLES - 1);

   typedef enum logic [0:0] {StNormal, StAdjust} modeT;

   // Bit order {swSEL, swADJ, btnR, btnP}
   logic [3:0] syncMeta;
   logic [3:0] syncOut;
   logic [1:0] btnSync;
   logic       adjSync;
   logic       selSync;

   logic [1:0]         dbLevel;
   logic [WidthDb-1:0] dbCount [2];
   logic [1:0]         press;
   logic               pressPause;
   logic               pressClear;

   modeT                  modeQ;
   logic                  modeChange;
   logic [WidthNorm-1:0]  divNorm;
   logic [WidthAdj-1:0]   divAdj;
   logic                  pausedQ;
   logic                  incSec;
   logic                  incMin;
   logic                  clearQ;

   logic [WidthBlink-1:0] divBlink;
   logic                  blinkPhase;
   logic                  blinkSec;
   logic                  blinkMin;

   assign btnSync    = syncOut[1:0];
   assign adjSync    = syncOut[2];
   assign selSync    = syncOut[3];
   assign pressPause = press[0];
   assign pressClear = press[1];
   assign modeChange = (modeQ == StAdjust) != adjSync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncMeta <= '0;
         syncOut  <= '0;
      end else begin
         syncMeta <= {bus.swSEL, bus.swADJ, bus.btnR, bus.btnP};
         syncOut  <= syncMeta;
      end
   end

   // The count tracks consecutive samples disagreeing with the accepted level; the
   // level flips on the DB_CYCLES-th one, and a rising flip raises a press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbLevel <= '0;
         press   <= '0;
         for (int i = 0; i < 2; i++) begin
            dbCount[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (btnSync[i] == dbLevel[i]) begin
               dbCount[i] <= '0;
            end else if (dbCount[i] == LastDb) begin
               dbLevel[i] <= btnSync[i];
               dbCount[i] <= '0;
               press[i]   <= btnSync[i];
            end else begin
               dbCount[i] <= dbCount[i] + WidthDb'(1);
            end
         end
      end
   end

   // Mode FSM, tick dividers and command outputs. A mode change or clear restarts
   // both dividers and swallows any tick due in that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         modeQ   <= StNormal;
         divNorm <= '0;
         divAdj  <= '0;
         pausedQ <= 1'b0;
         incSec  <= 1'b0;
         incMin  <= 1'b0;
         clearQ  <= 1'b0;
      end else begin
         incSec <= 1'b0;
         incMin <= 1'b0;
         clearQ <= pressClear;
         if (pressPause) begin
            pausedQ <= ~pausedQ;
         end
         if (modeChange) begin
            modeQ   <= adjSync ? StAdjust : StNormal;
            divNorm <= '0;
            divAdj  <= '0;
         end else if (pressClear) begin
            divNorm <= '0;
            divAdj  <= '0;
         end else begin
            unique case (modeQ)
               StNormal: begin
                  divAdj <= '0;
                  if (!pausedQ) begin
                     if (divNorm == LastNorm) begin
                        divNorm <= '0;
                        incSec  <= 1'b1;
                     end else begin
                        divNorm <= divNorm + WidthNorm'(1);
                     end
                  end
               end
               StAdjust: begin
                  divNorm <= '0;
                  if (!pausedQ) begin
                     if (divAdj == LastAdj) begin
                        divAdj <= '0;
                        incMin <= selSync;
                        incSec <= ~selSync;
                     end else begin
                        divAdj <= divAdj + WidthAdj'(1);
                     end
                  end
               end
               default: modeQ <= StNormal;
            endcase
         end
      end
   end

   // Blink timing is free-running so the display cadence ignores pause and mode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divBlink   <= '0;
         blinkPhase <= 1'b0;
         blinkSec   <= 1'b0;
         blinkMin   <= 1'b0;
      end else begin
         if (divBlink == LastBlink) begin
            divBlink   <= '0;
            blinkPhase <= ~blinkPhase;
         end else begin
            divBlink <= divBlink + WidthBlink'(1);
         end
         blinkMin <= adjSync & selSync & blinkPhase;
         blinkSec <= adjSync & ~selSync & blinkPhase;
      end
   end

   assign bus.inc_sec   = incSec;
   assign bus.inc_min   = incMin;
   assign bus.clear     = clearQ;
   assign bus.paused    = pausedQ;
   assign bus.adj_mode  = adjSync;
   assign bus.blink_sec = blinkSec;
   assign bus.blink_min = blinkMin;

endmodule
